// File: rtl/key_pulse_pkg.sv
// Shared types and constants for the key pulse generator: channel state
// encoding, default timing at 100 MHz and the key_code width helper.
package key_pulse_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        PRESS    = 2'd2,
        REPEAT   = 2'd3
    } chan_state_t;

    // 0.5 s before the first repeat, then 0.1 s between repeats, at 100 MHz.
    localparam int DEFAULT_HOLD_CYCLES   = 50_000_000;
    localparam int DEFAULT_REPEAT_CYCLES = 10_000_000;

    function automatic int code_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One button channel: two-flop resynchroniser, press/hold/repeat FSM and the
// shared hold/repeat counter. o_fire is the strobe the top level registers.
module key_channel
    import key_pulse_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_lvl,
    input  logic i_enable,
    output logic o_fire,
    output logic o_held
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_warm;
    chan_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_held;
    logic             w_s;

    assign w_s    = r_sync2;
    assign o_held = r_held;

    // Release wins over an expiry on the same edge because w_s gates every term.
    assign o_fire = i_enable && w_s &&
                    ((r_state == IDLE) ||
                     ((r_state == PRESS)  && (r_cnt == HOLD_LAST)) ||
                     ((r_state == REPEAT) && (r_cnt == REPEAT_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_warm  <= 2'b00;
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
            r_held  <= 1'b0;
        end else begin
            r_sync1 <= i_key_lvl;
            r_sync2 <= r_sync1;
            // The synchroniser holds reset zeros for two edges; a key held
            // through reset must not be mistaken for a release during that time.
            r_warm  <= {r_warm[0], 1'b1};
            if (!i_enable) begin
                r_state <= WAIT_LOW;
                r_cnt   <= '0;
                r_held  <= 1'b0;
            end else begin
                case (r_state)
                    WAIT_LOW: begin
                        if (!w_s && r_warm[1]) r_state <= IDLE;
                    end
                    IDLE: begin
                        if (w_s) begin
                            r_state <= PRESS;
                            r_cnt   <= '0;
                        end
                    end
                    PRESS: begin
                        if (!w_s) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == HOLD_LAST) begin
                            r_state <= REPEAT;
                            r_held  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!w_s) begin
                            r_state <= IDLE;
                            r_held  <= 1'b0;
                            r_cnt   <= '0;
                        end else if (r_cnt == REPEAT_LAST) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= WAIT_LOW;
                endcase
            end
        end
    end

endmodule

// File: rtl/key_pulse_gen.sv
// Turns debounced button levels into single-cycle command pulses with
// hold-to-repeat, plus a lowest-index-wins key code.
module key_pulse_gen
    import key_pulse_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_KEYS-1:0]                 key_lvl,
    input  logic                              enable,
    output logic [N_KEYS-1:0]                 pulse,
    output logic [N_KEYS-1:0]                 held,
    output logic                              key_valid,
    output logic [code_width(N_KEYS)-1:0]     key_code
);

    localparam int CODE_W = code_width(N_KEYS);

    logic [N_KEYS-1:0] w_fire;
    logic [CODE_W-1:0] w_code;
    logic [N_KEYS-1:0] r_pulse;
    logic              r_key_valid;
    logic [CODE_W-1:0] r_key_code;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_chan
            key_channel #(
                .HOLD_CYCLES   (HOLD_CYCLES),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .i_key_lvl (key_lvl[gi]),
                .i_enable  (enable),
                .o_fire    (w_fire[gi]),
                .o_held    (held[gi])
            );
        end
    endgenerate

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        w_code = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (w_fire[i]) w_code = CODE_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse     <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
        end else begin
            r_pulse     <= w_fire;
            r_key_valid <= |w_fire;
            r_key_code  <= w_code;
        end
    end

    assign pulse     = r_pulse;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed scenarios plus random key activity,
// checked every cycle against a time-since-press reference model.
module tb_key_pulse_gen;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int REP  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [N-1:0] key_lvl;
    logic [N-1:0] pulse;
    logic [N-1:0] held;
    logic         key_valid;
    logic [1:0]   key_code;

    always #5 clk = ~clk;

    key_pulse_gen #(
        .N_KEYS        (N),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_lvl   (key_lvl),
        .enable    (enable),
        .pulse     (pulse),
        .held      (held),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int m_edges  = 0;
    logic [N-1:0] m_s1, m_s2, m_armed, m_pressed, exp_pulse, exp_held;
    int m_start [N];
    int pulse_cnt [N];
    int hold_left [N];
    int base_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else begin
            $display("FAIL %s cyc=%0d observed=%0h required=%0h", tag, cyc, obs, req);
            $error("%s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic logic [1:0] lowest(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return 2'(k);
        return 2'd0;
    endfunction

    // One clock edge: update the model from the inputs seen at the edge,
    // then compare every output 1 time unit later.
    task automatic step();
        logic [N-1:0] s;
        int d;
        @(posedge clk);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_edges = 0;
            m_armed = '0; m_pressed = '0; exp_pulse = '0; exp_held = '0;
        end else begin
            s = m_s2;
            exp_pulse = '0;
            for (int k = 0; k < N; k++) begin
                if (!enable) begin
                    m_armed[k] = 1'b0; m_pressed[k] = 1'b0; exp_held[k] = 1'b0;
                end else if (!m_armed[k]) begin
                    if (m_edges >= 2 && !s[k]) m_armed[k] = 1'b1;
                end else if (!s[k]) begin
                    m_pressed[k] = 1'b0; exp_held[k] = 1'b0;
                end else if (!m_pressed[k]) begin
                    m_pressed[k] = 1'b1; m_start[k] = cyc; exp_pulse[k] = 1'b1;
                end else begin
                    d = cyc - m_start[k];
                    if (d == HOLD || (d > HOLD && (d - HOLD) % REP == 0)) exp_pulse[k] = 1'b1;
                    exp_held[k] = (d >= HOLD);
                end
            end
            m_s2 = m_s1;
            m_s1 = key_lvl;
            m_edges++;
        end
        cyc++;
        #1;
        for (int k = 0; k < N; k++) if (pulse[k] === 1'b1) pulse_cnt[k]++;
        check("pulse", 32'(pulse), 32'(exp_pulse));
        check("held", 32'(held), 32'(exp_held));
        check("key_valid", 32'(key_valid), 32'(|exp_pulse));
        check("key_code", 32'(key_code), 32'(lowest(exp_pulse)));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin pulse_cnt[k] = 0; m_start[k] = 0; hold_left[k] = 0; end
        rst = 1'b1; enable = 1'b1; key_lvl = '0;
        steps(3);
        check("reset_pulse", 32'(pulse), 32'd0);
        check("reset_code", 32'(key_code), 32'd0);
        rst = 1'b0;
        steps(4);

        // Short press of key 1: one pulse two edges after the first sample.
        key_lvl = 4'b0010;
        steps(3);
        check("k1_pulse", 32'(pulse), 32'h2);
        check("k1_code", 32'(key_code), 32'd1);
        check("k1_valid", 32'(key_valid), 32'd1);
        key_lvl = '0;
        base_cnt = pulse_cnt[1];
        steps(10);
        check("k1_no_repeat", 32'(pulse_cnt[1] - base_cnt), 32'd0);

        // Key 0 held 20 cycles: pulses at t, t+8, t+11, t+14, t+17.
        base_cnt = pulse_cnt[0];
        key_lvl = 4'b0001;
        steps(20);
        key_lvl = '0;
        steps(6);
        check("k0_hold_count", 32'(pulse_cnt[0] - base_cnt), 32'd5);
        check("k0_held_clear", 32'(held), 32'd0);

        // Keys 2 and 3 on the same edge.
        key_lvl = 4'b1100;
        steps(3);
        check("k23_pulse", 32'(pulse), 32'hC);
        check("k23_code", 32'(key_code), 32'd2);
        key_lvl = '0;
        steps(5);

        // Key 0 held through reset: silent until released and pressed again.
        key_lvl = 4'b0001;
        rst = 1'b1;
        steps(3);
        rst = 1'b0;
        base_cnt = pulse_cnt[0];
        steps(20);
        check("k0_thru_reset", 32'(pulse_cnt[0] - base_cnt), 32'd0);
        key_lvl = '0;
        steps(4);
        key_lvl = 4'b0001;
        steps(3);
        check("k0_repress", 32'(pulse), 32'h1);
        key_lvl = '0;
        steps(5);

        // Disable while key 1 repeats, re-enable while still held.
        key_lvl = 4'b0010;
        steps(14);
        check("k1_in_repeat", 32'(held), 32'h2);
        enable = 1'b0;
        steps(1);
        check("dis_held", 32'(held), 32'd0);
        check("dis_pulse", 32'(pulse), 32'd0);
        enable = 1'b1;
        base_cnt = pulse_cnt[1];
        steps(12);
        check("reen_silent", 32'(pulse_cnt[1] - base_cnt), 32'd0);
        key_lvl = '0;
        steps(4);
        key_lvl = 4'b0010;
        steps(3);
        check("reen_press", 32'(pulse), 32'h2);
        key_lvl = '0;
        steps(5);

        // Key 0 released exactly on its second repeat expiry (d = 14).
        base_cnt = pulse_cnt[0];
        key_lvl = 4'b0001;
        steps(14);
        key_lvl = '0;
        steps(1);
        steps(2);
        check("rel_on_expiry_cnt", 32'(pulse_cnt[0] - base_cnt), 32'd3);
        check("rel_on_expiry_held", 32'(held), 32'd0);
        steps(4);

        // Random key activity with occasional disable and reset.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (hold_left[k] == 0) begin
                    key_lvl[k] = ~key_lvl[k];
                    hold_left[k] = int'($urandom_range(1, 25));
                end else begin
                    hold_left[k]--;
                end
            end
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; enable = 1'b1; key_lvl = '0;
        steps(6);
        check("final_idle", 32'(pulse), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
